// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the ALU and the
// operand loader, plus the loader's state encoding (driven onto status LEDs).
package alu_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;

  // Opcode the loader presents after reset, so the ALU computes A+B by default.
  localparam logic [OPCODE_W-1:0] OP_RESET = OP_ADD;

  // Encoding is visible on the stage LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/debouncer.sv
// Push-button front end: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted rising level.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic load_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta_reg;
  logic             btn_s_reg;
  logic             deb_reg;
  logic             deb_q_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_reg <= 1'b0;
      btn_s_reg    <= 1'b0;
    end else begin
      btn_meta_reg <= btn_in;
      btn_s_reg    <= btn_meta_reg;
    end
  end

  // Accept a new level only after it differs from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      deb_reg <= 1'b0;
    end else if (btn_s_reg == deb_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      deb_reg <= btn_s_reg;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Delayed copy of the accepted level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q_reg <= 1'b0;
    end else begin
      deb_q_reg <= deb_reg;
    end
  end

  assign load_pulse = deb_reg & ~deb_q_reg;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads switch-bank values into ALU operand registers in the order
// A -> B -> opcode, one register per debounced button press.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int BUS_SIZE        = 8,
  parameter int OPCODE_SIZE     = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUS_SIZE-1:0]    sw,
  input  logic                   btn_load,
  output logic [BUS_SIZE-1:0]    num1,
  output logic [BUS_SIZE-1:0]    num2,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   valid,
  output logic [1:0]             stage
);

  logic [BUS_SIZE-1:0]    sw_meta_reg;
  logic [BUS_SIZE-1:0]    sw_s_reg;
  logic                   load_pulse;
  loader_state_t          state_reg;
  loader_state_t          state_next;
  logic                   ld_num1;
  logic                   ld_num2;
  logic                   ld_op;
  logic [BUS_SIZE-1:0]    num1_reg;
  logic [BUS_SIZE-1:0]    num2_reg;
  logic [OPCODE_SIZE-1:0] opcode_reg;

  // Bring the asynchronous switch bank into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_reg <= '0;
      sw_s_reg    <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_s_reg    <= sw_meta_reg;
    end
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_load),
    .load_pulse(load_pulse)
  );

  // Sequence the loads; a press in READY starts a fresh set at operand A.
  always_comb begin
    state_next = state_reg;
    ld_num1    = 1'b0;
    ld_num2    = 1'b0;
    ld_op      = 1'b0;
    if (load_pulse) begin
      case (state_reg)
        LOAD_A: begin
          ld_num1    = 1'b1;
          state_next = LOAD_B;
        end
        LOAD_B: begin
          ld_num2    = 1'b1;
          state_next = LOAD_OP;
        end
        LOAD_OP: begin
          ld_op      = 1'b1;
          state_next = READY;
        end
        default: begin
          ld_num1    = 1'b1;
          state_next = LOAD_B;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LOAD_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand registers; unselected registers hold their value.
  always_ff @(posedge clk) begin
    if (reset) begin
      num1_reg   <= '0;
      num2_reg   <= '0;
      opcode_reg <= OPCODE_SIZE'(OP_RESET);
    end else begin
      if (ld_num1) num1_reg   <= sw_s_reg;
      if (ld_num2) num2_reg   <= sw_s_reg;
      if (ld_op)   opcode_reg <= sw_s_reg[OPCODE_SIZE-1:0];
    end
  end

  assign num1   = num1_reg;
  assign num2   = num2_reg;
  assign opcode = opcode_reg;
  assign stage  = state_reg;
  assign valid  = (state_reg == READY);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a short debounce time.
module tb_alu_operand_loader;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       btn_load;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [5:0] opcode;
  logic       valid;
  logic [1:0] stage;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: operand set contents and load position.
  logic [7:0] m_num1;
  logic [7:0] m_num2;
  logic [5:0] m_op;
  int         m_stage;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] e_num1;
    logic [7:0] e_num2;
    logic [5:0] e_op;
    logic [1:0] e_stage;
  } vec_t;

  vec_t vecs[4];

  alu_operand_loader #(
    .BUS_SIZE(8),
    .OPCODE_SIZE(6),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn_load(btn_load),
    .num1(num1),
    .num2(num2),
    .opcode(opcode),
    .valid(valid),
    .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_num1  = 8'h00;
    m_num2  = 8'h00;
    m_op    = 6'b100000;
    m_stage = 0;
  endtask

  // One accepted press loads the register at the current position.
  task automatic model_load(input logic [7:0] v);
    case (m_stage)
      0: begin m_num1 = v;      m_stage = 1; end
      1: begin m_num2 = v;      m_stage = 2; end
      2: begin m_op   = v[5:0]; m_stage = 3; end
      default: begin m_num1 = v; m_stage = 1; end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, " num1"},   {24'd0, num1},   {24'd0, m_num1});
    check({tag, " num2"},   {24'd0, num2},   {24'd0, m_num2});
    check({tag, " opcode"}, {26'd0, opcode}, {26'd0, m_op});
    check({tag, " stage"},  {30'd0, stage},  m_stage);
    check({tag, " valid"},  {31'd0, valid},  {31'd0, (m_stage == 3)});
  endtask

  // Clean press: high for len cycles then low for gap cycles; sw held throughout.
  task automatic press(input logic [7:0] v, input int len, input int gap);
    sw = v;
    btn_load = 1'b1;
    repeat (len) tick();
    btn_load = 1'b0;
    repeat (gap) tick();
    if (len >= D) model_load(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{sw: 8'h25, e_num1: 8'h25, e_num2: 8'h00, e_op: 6'b100000, e_stage: 2'd1};
    vecs[1] = '{sw: 8'h0F, e_num1: 8'h25, e_num2: 8'h0F, e_op: 6'b100000, e_stage: 2'd2};
    vecs[2] = '{sw: 8'h22, e_num1: 8'h25, e_num2: 8'h0F, e_op: 6'b100010, e_stage: 2'd3};
    vecs[3] = '{sw: 8'hA0, e_num1: 8'hA0, e_num2: 8'h0F, e_op: 6'b100010, e_stage: 2'd1};

    reset = 1'b1;
    sw = 8'h00;
    btn_load = 1'b0;
    model_reset();
    do_reset();

    // Reset then idle for 50 cycles.
    check_all("reset");
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 10 == 9) check_all($sformatf("idle%0d", i));
    end

    // Full sequence plus wrap, with exact write-edge latency.
    for (int i = 0; i < 4; i++) begin
      sw = vecs[i].sw;
      btn_load = 1'b1;
      repeat (6) tick();
      check_all($sformatf("vec%0d pre", i));
      tick();
      model_load(vecs[i].sw);
      check($sformatf("vec%0d num1", i),   {24'd0, num1},   {24'd0, vecs[i].e_num1});
      check($sformatf("vec%0d num2", i),   {24'd0, num2},   {24'd0, vecs[i].e_num2});
      check($sformatf("vec%0d opcode", i), {26'd0, opcode}, {26'd0, vecs[i].e_op});
      check($sformatf("vec%0d stage", i),  {30'd0, stage},  {30'd0, vecs[i].e_stage});
      check($sformatf("vec%0d valid", i),  {31'd0, valid},  {31'd0, (vecs[i].e_stage == 2'd3)});
      btn_load = 1'b0;
      repeat (10) tick();
      $display("vec %0d: sw=%h num1=%h num2=%h opcode=%b stage=%0d valid=%0d",
               i, vecs[i].sw, num1, num2, opcode, stage, valid);
    end

    // Bounce: toggle every 2 cycles for 20 cycles, then low.
    sw = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      repeat (2) tick();
    end
    btn_load = 1'b0;
    repeat (10) tick();
    check_all("bounce");

    // Short 3-cycle pulses are ignored; a 5-cycle pulse loads once.
    for (int i = 0; i < 3; i++) press(8'h11 + 8'(i), 3, 10);
    check_all("short");
    press(8'h77, 5, 10);
    check_all("pulse5");

    // Held button loads once; re-press loads again.
    press(8'h3C, 200, 10);
    check_all("held");
    press(8'hC3, 5, 10);
    check_all("repress");

    // Randomized clean presses against the reference.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] v;
      int len;
      v = 8'($urandom);
      len = $urandom_range(1, 12);
      press(v, len, $urandom_range(8, 15));
      check_all($sformatf("rand%0d", i));
      $display("rand %0d: sw=%h len=%0d stage=%0d num1=%h num2=%h opcode=%b",
               i, v, len, stage, num1, num2, opcode);
    end

    // Reset in LOAD_OP while the button is held mid-debounce.
    do_reset();
    press(8'h01, 5, 10);
    press(8'h02, 5, 10);
    check_all("pre_rst");
    sw = 8'hE7;
    btn_load = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_all("mid_rst");
    repeat (6) tick();
    check_all("post_rst pre");
    tick();
    model_load(8'hE7);
    check_all("post_rst load");
    btn_load = 1'b0;
    repeat (10) tick();
    check_all("post_rst release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
